serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Receive end of the team's asynchronous serial frame link. Deserialises the single-wire frame format that the transmit side produces: start bit, DATA_W data bits LSB first, optional even-parity bit, one stop bit.
- Presents each received word on a valid/ready output port with a one-word holding register.
- Sits between a top-level pad input and a consumer such as a $display-driven monitor or a FIFO in simulation testbenches.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 16, clk cycles per bit period (>=4, even).
- PARITY_EN, 1, 1 = even-parity bit present between data and stop; 0 = absent.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- rxd  input  1  serial line, idle high, asynchronous to clk
- data  output  DATA_W  received word, held stable while valid=1
- valid  output  1  data holds an unconsumed word
- ready  input  1  consumer accepts data when valid&ready on a clk edge
- parity_err  output  1  sticky; frame with bad parity seen
- frame_err  output  1  sticky; stop bit sampled low
- overrun  output  1  sticky; completed frame dropped because holding register was full
- err_clr  input  1  synchronous clear of all three sticky flags
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; synchroniser flops 1; FSM IDLE; bit and cycle counters 0. Reset mid-frame abandons the frame and raises no flags.
- rxd passes through a 2-flop synchroniser (rxd_s). All FSM decisions use rxd_s. Input-to-FSM latency is 2 cycles.
- Bit counter width: clog2(CLKS_PER_BIT). Counter wraps to 0 at CLKS_PER_BIT-1.
- IDLE: on rxd_s==0, go to START and clear the cycle counter.
- START: at count CLKS_PER_BIT/2-1 (mid-bit):
  - if rxd_s==1, treat as a glitch and return to IDLE with no flags raised;
  - otherwise clear the counter and go to DATA.
- DATA: sample rxd_s at each full CLKS_PER_BIT count into shift[idx], starting at idx 0 (LSB first). After DATA_W samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit. Parity is good when the XOR of the data bits and the sampled bit equals 0.
- STOP: sample at full count.
  - stop==0: set frame_err, discard the word, go to IDLE immediately.
  - stop==1: the word is complete.
- Word complete, valid==0: load data and set valid on the same edge that leaves STOP. If parity failed, still load the word and also set parity_err.
- Word complete, valid==1 and ready==0: keep the existing data, set overrun, discard the new word.
- Word complete, valid==1 and ready==1 on the same edge: treat as accepted-then-loaded. The new word replaces the old one, valid stays 1, no overrun.
- Handshake: valid falls on the edge where valid&ready. data may change only on a load.
- After a good stop the FSM returns to IDLE. A low on rxd_s in the next cycle starts a new frame (back-to-back frames supported).
- Simultaneous set and err_clr: set wins.
- busy=1 in every state except IDLE.
- Frame latency: valid rises 2 + CLKS_PER_BIT/2 + (DATA_W+PARITY_EN+1)*CLKS_PER_BIT cycles after the falling start edge, ±1 cycle of synchroniser phase.

Decomposition:
- Package serial_frame_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3 bits;
  - constant LINE_IDLE = 1'b1;
  - function bit_cnt_w(CLKS_PER_BIT) returning the counter width.
- The transmitter shares the same package.
- One sub-module: serial_sync2, a 2-flop synchroniser with a reset value parameter, reused by other pad inputs.

Test Plan:
- Default parameters, send 8'hA5 with correct parity 0 and stop 1, ready=1 -> data=8'hA5 and valid for exactly 1 cycle; no flags; busy returns to 0.
- Send 8'h3C then 8'hC3 back-to-back with ready=0 -> data stays 8'h3C, valid=1, overrun=1. Assert err_clr -> overrun=0, data still 8'h3C.
- Send 8'h01 with parity bit 0 (wrong) -> data=8'h01, valid=1, parity_err=1.
- Send 8'hFF with stop bit 0 -> valid stays 0, frame_err=1, FSM back in IDLE. A following correct frame 8'h55 is received cleanly.
- Drive a low pulse on rxd of 4 cycles (< CLKS_PER_BIT/2) -> no valid, no flags, busy returns to 0 after the mid-bit check.
- Assert rst during the DATA state of frame 8'h77 -> all outputs 0 immediately. Then send 8'h12 with PARITY_EN=0, DATA_W=5 instance -> data=5'h12.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// ============================================================================
// serial_frame_pkg: shared types and helpers for the serial frame link
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int bit_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sync2.sv
// ============================================================================
// serial_sync2: two-flop synchroniser for asynchronous pad inputs
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// serial_frame_rx: serial frame receiver with one-word valid/ready output
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic              busy
);

    localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DATA_W - 1);

    logic              w_rxd_s;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bad;

    serial_sync2 #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (w_rxd_s)
    );

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Clears come first so that any flag set later in this cycle wins.
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rxd_s != LINE_IDLE) begin
                        r_cnt   <= '0;
                        r_state <= START;
                    end
                end

                START: begin
                    if (r_cnt == c_cnt_mid) begin
                        if (w_rxd_s == LINE_IDLE) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt     <= '0;
                            r_idx     <= '0;
                            r_par_bad <= 1'b0;
                            r_state   <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == c_cnt_full) begin
                        r_cnt <= '0;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_shift[i] <= w_rxd_s;
                            end
                        end
                        if (r_idx == c_idx_last) begin
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (r_cnt == c_cnt_full) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ w_rxd_s;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == c_cnt_full) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rxd_s != LINE_IDLE) begin
                            frame_err <= 1'b1;
                        end else if (valid && !ready) begin
                            overrun <= 1'b1;
                        end else begin
                            // A simultaneous accept frees the holding register for this word.
                            data  <= r_shift;
                            valid <= 1'b1;
                            if (r_par_bad) begin
                                parity_err <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// ============================================================================
// tb_serial_frame_rx: directed self-checking bench for serial_frame_rx
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       rxd0 = 1'b1, ready0 = 1'b0, err_clr0 = 1'b0;
    logic [7:0] data0;
    logic       valid0, perr0, ferr0, ovr0, busy0;

    logic       rxd1 = 1'b1, ready1 = 1'b0, err_clr1 = 1'b0;
    logic [4:0] data1;
    logic       valid1, perr1, ferr1, ovr1, busy1;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         vcnt  = 0;
    logic [7:0] got   = 8'h00;

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd0), .data(data0), .valid(valid0), .ready(ready0),
        .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .err_clr(err_clr0), .busy(busy0)
    );

    serial_frame_rx #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .data(data1), .valid(valid1), .ready(ready1),
        .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .err_clr(err_clr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Consumer model: counts valid cycles and captures accepted words.
    always @(posedge clk) begin
        if (valid0) vcnt <= vcnt + 1;
        if (valid0 && ready0) got <= data0;
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rxd0 = b;
        else            rxd1 = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input int which, input logic [15:0] d, input int nbits,
                       input bit par_en, input logic par, input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(which, d[i]);
        if (par_en) drive_bit(which, par);
        drive_bit(which, stop);
        if (which == 0) rxd0 = 1'b1;
        else            rxd1 = 1'b1;
    endtask

    task automatic pulse_clr0();
        err_clr0 = 1'b1;
        @(negedge clk);
        err_clr0 = 1'b0;
    endtask

    initial begin
        int v0;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_valid", 16'(valid0), 16'h0);
        check("rst_data",  16'(data0),  16'h0);
        check("rst_flags", 16'({perr0, ferr0, ovr0}), 16'h0);
        check("rst_busy",  16'(busy0),  16'h0);
        check("rst_dut1",  16'({valid1, data1, busy1}), 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            ready0 = 1'b1;
            repeat (2) @(negedge clk);
            pulse_clr0();
            ready0 = vecs[i].rdy;
            v0 = vcnt;
            send(0, 16'(vecs[i].d), 8, 1'b1, vecs[i].par, vecs[i].stop);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_valid", i), 16'(valid0), 16'(vecs[i].exp_valid));
            check($sformatf("v%0d_perr", i),  16'(perr0),  16'(vecs[i].exp_perr));
            check($sformatf("v%0d_ferr", i),  16'(ferr0),  16'(vecs[i].exp_ferr));
            check($sformatf("v%0d_ovr", i),   16'(ovr0),   16'h0);
            check($sformatf("v%0d_busy", i),  16'(busy0),  16'h0);
            if (vecs[i].rdy) begin
                check($sformatf("v%0d_vcycles", i), 16'(vcnt - v0), vecs[i].exp_ferr ? 16'h0 : 16'h1);
                if (!vecs[i].exp_ferr)
                    check($sformatf("v%0d_got", i), 16'(got), 16'(vecs[i].exp_data));
            end else begin
                check($sformatf("v%0d_data", i), 16'(data0), 16'(vecs[i].exp_data));
            end
        end

        // Overrun: second word dropped while the first is still held.
        ready0 = 1'b1;
        repeat (2) @(negedge clk);
        pulse_clr0();
        ready0 = 1'b0;
        send(0, 16'h3C, 8, 1'b1, 1'b0, 1'b1);
        send(0, 16'hC3, 8, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_data",  16'(data0),  16'h3C);
        check("ovr_valid", 16'(valid0), 16'h1);
        check("ovr_flag",  16'(ovr0),   16'h1);
        pulse_clr0();
        check("ovr_clr",       16'(ovr0),   16'h0);
        check("ovr_clr_data",  16'(data0),  16'h3C);
        check("ovr_clr_valid", 16'(valid0), 16'h1);
        ready0 = 1'b1;
        @(negedge clk);
        check("ovr_drain_valid", 16'(valid0), 16'h0);
        check("ovr_drain_data",  16'(data0),  16'h3C);

        // Short low glitch on the line is rejected at the mid-bit check.
        rxd0 = 1'b0;
        repeat (4) @(negedge clk);
        rxd0 = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", 16'(busy0), 16'h1);
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", 16'(busy0), 16'h0);
        check("glitch_valid",   16'(valid0), 16'h0);
        check("glitch_flags",   16'({perr0, ferr0, ovr0}), 16'h0);

        // Reset in the middle of a frame with a word and a flag already held.
        ready0 = 1'b0;
        send(0, 16'h01, 8, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("pre_rst_held", 16'({valid0, perr0, data0}), 16'h301);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        check("mid_busy", 16'(busy0), 16'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 16'(valid0), 16'h0);
        check("mid_rst_data",  16'(data0),  16'h0);
        check("mid_rst_flags", 16'({perr0, ferr0, ovr0}), 16'h0);
        check("mid_rst_busy",  16'(busy0),  16'h0);
        rxd0 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_quiet", 16'({valid0, busy0, perr0, ferr0, ovr0}), 16'h0);

        // Five-bit, no-parity instance.
        send(1, 16'h12, 5, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("d1_data",  16'(data1),  16'h12);
        check("d1_valid", 16'(valid1), 16'h1);
        check("d1_flags", 16'({perr1, ferr1, ovr1}), 16'h0);
        check("d1_busy",  16'(busy1),  16'h0);
        ready1 = 1'b1;
        @(negedge clk);
        check("d1_accept", 16'(valid1), 16'h0);
        ready1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
